// File: rtl/quad_adder_pkg.sv
// Shared encodings for the quad adder handshake scheduler: FSM states, error codes, lane count.
package quad_adder_pkg;

  localparam int NUM_LANES = 4;
  localparam logic [NUM_LANES-1:0] LANES_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_CFG           = 2'd1,
    ERR_LAST_MISMATCH = 2'd2,
    ERR_TIMEOUT       = 2'd3
  } err_code_t;

endpackage

// File: rtl/quad_stall_timer.sv
// Counts consecutive stall cycles; expire is asserted on the TIMEOUT_CYC-th consecutive inc.
module quad_stall_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  assign expire = inc & ~clear & (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (reset || clear || !inc || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_adder_sched.sv
// Joins four AXI-Stream lanes for the quad adder: zero-latency valid join, tlast alignment,
// lane-skew timeout, abort/error flush and status. Handshake: a lane beat transfers when
// s_axis_tvalid & s_axis_tready; tready is derived from valid (never the reverse).
module quad_adder_sched
  import quad_adder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_WIDTH   = 32,
  parameter int BEAT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NUM_LANES-1:0]  cfg_lane_en,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  cfg_abort,
  input  logic                  cfg_clear,
  input  logic [NUM_LANES-1:0]  s_axis_tvalid,
  input  logic [NUM_LANES-1:0]  s_axis_tlast,
  output logic [NUM_LANES-1:0]  s_axis_tready,
  output logic                  add_en,
  output logic [NUM_LANES-1:0]  add_lane_mask,
  output logic                  add_last,
  input  logic                  add_ready,
  output logic [1:0]            sts_state,
  output logic [1:0]            sts_err_code,
  output logic [CNT_WIDTH-1:0]  sts_frame_cnt,
  output logic [BEAT_WIDTH-1:0] sts_beat_cnt
);

  state_t                state_q, state_d;
  err_code_t             err_q, err_d;
  logic [NUM_LANES-1:0]  mask_q, mask_d;
  logic [NUM_LANES-1:0]  done_q, done_d;
  logic [CNT_WIDTH-1:0]  frame_q, frame_d;
  logic [BEAT_WIDTH-1:0] beat_q, beat_d;
  logic                  stop_q, stop_d;

  logic                  run;
  logic                  join_all;
  logic                  fire;
  logic [NUM_LANES-1:0]  last_l;
  logic                  frame_end;
  logic                  stall_inc;
  logic                  stall_clr;
  logic                  stall_expire;
  logic [NUM_LANES-1:0]  drain_acc;
  logic [BEAT_WIDTH-1:0] beat_inc;

  assign run       = (state_q == ST_RUN);
  assign join_all  = &(s_axis_tvalid | ~mask_q);
  // Abort wins over a beat that would otherwise fire in the same cycle.
  assign fire      = run & join_all & add_ready & ~cfg_abort;
  assign last_l    = s_axis_tlast & mask_q;
  assign frame_end = (last_l == mask_q);
  assign stall_inc = run & add_ready & ~join_all & (|(s_axis_tvalid & mask_q));
  assign stall_clr = ~stall_inc;
  assign drain_acc = s_axis_tvalid & mask_q & ~done_q;
  assign beat_inc  = (beat_q == '1) ? beat_q : beat_q + 1'b1;

  quad_stall_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_stall_timer (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (stall_clr),
    .inc    (stall_inc),
    .expire (stall_expire)
  );

  always_comb begin
    s_axis_tready = '0;
    case (state_q)
      ST_RUN:   s_axis_tready = mask_q & {NUM_LANES{fire}};
      ST_DRAIN: s_axis_tready = mask_q & ~done_q;
      default:  s_axis_tready = '0;
    endcase
  end

  assign add_en        = fire;
  assign add_last      = fire & frame_end;
  assign add_lane_mask = mask_q;
  assign sts_state     = state_q;
  assign sts_err_code  = err_q;
  assign sts_frame_cnt = frame_q;
  assign sts_beat_cnt  = beat_q;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    mask_d  = mask_q;
    done_d  = done_q;
    frame_d = frame_q;
    beat_d  = beat_q;
    stop_d  = stop_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start && !cfg_abort && !cfg_stop) begin
          if (cfg_lane_en != '0) begin
            mask_d  = cfg_lane_en;
            err_d   = ERR_NONE;
            beat_d  = '0;
            stop_d  = 1'b0;
            done_d  = '0;
            state_d = ST_RUN;
          end else begin
            err_d = ERR_CFG;
          end
        end
      end
      ST_RUN: begin
        if (cfg_abort) begin
          stop_d  = 1'b0;
          done_d  = '0;
          state_d = (beat_q == '0) ? ST_IDLE : ST_DRAIN;
        end else if (fire) begin
          beat_d = beat_inc;
          if (frame_end) begin
            frame_d = frame_q + 1'b1;
            beat_d  = '0;
            if (stop_q || cfg_stop) begin
              stop_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (last_l == '0) begin
            stop_d = stop_q | cfg_stop;
          end else begin
            // Misaligned tlast: remember which lanes already ended so the flush skips them.
            err_d   = ERR_LAST_MISMATCH;
            done_d  = last_l;
            state_d = ST_ERROR;
          end
        end else if (stall_expire) begin
          err_d   = ERR_TIMEOUT;
          done_d  = '0;
          state_d = ST_ERROR;
        end else if (cfg_stop) begin
          if (beat_q == '0) begin
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (cfg_clear) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        done_d = done_q | (drain_acc & s_axis_tlast);
        if ((done_q | ~mask_q) == LANES_ALL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      mask_q  <= '0;
      done_q  <= '0;
      frame_q <= '0;
      beat_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      beat_q  <= beat_d;
      stop_q  <= stop_d;
    end
  end

endmodule
